univ_shift_reg: RTL and testbench

Parametrised universal register that generalises the 4-bit parallel-in/parallel-out register. It adds serial I/O and load, clear, shift and rotate modes. A start/busy/done sequencer performs multi-step shifts or rotates of a programmable step count, one step per clock. Used as a generic datapath register or serialiser/deserialiser between RTL blocks.

---
 rtl/univ_shift_reg.sv | 131 +++++++++++++
 tb/tb_univ_shift_reg.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/load/clear plus shift and rotate commands.
// Shifts and rotates run for a programmable number of steps, one per clock.
module univ_shift_reg #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] steps,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    // Handshake: a command is accepted on a rising edge where start=1 and
    // busy=0; done pulses for one cycle at the edge the command completes,
    // and a new start may be presented in that same cycle.

    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_sout;
    logic             r_done;

    logic [2:0]       w_op;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_dout_step;
    logic             w_sout_step;

    // The step datapath follows the latched mode while running, else the live one.
    assign w_op       = (r_state == ST_RUN) ? r_mode : mode;
    assign w_is_shift = (mode == MODE_SHL) || (mode == MODE_SHR) ||
                        (mode == MODE_ROL) || (mode == MODE_ROR);

    always_comb begin
        w_dout_step = r_dout;
        w_sout_step = r_sout;
        case (w_op)
            MODE_SHL: begin
                w_dout_step = {r_dout[WIDTH-2:0], sin};
                w_sout_step = r_dout[WIDTH-1];
            end
            MODE_SHR: begin
                w_dout_step = {sin, r_dout[WIDTH-1:1]};
                w_sout_step = r_dout[0];
            end
            MODE_ROL: begin
                w_dout_step = {r_dout[WIDTH-2:0], r_dout[WIDTH-1]};
                w_sout_step = r_dout[WIDTH-1];
            end
            MODE_ROR: begin
                w_dout_step = {r_dout[0], r_dout[WIDTH-1:1]};
                w_sout_step = r_dout[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_mode  <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_sout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode == MODE_LOAD) begin
                            r_dout <= din;
                            r_done <= 1'b1;
                        end else if (mode == MODE_CLR) begin
                            r_dout <= '0;
                            r_done <= 1'b1;
                        end else if (w_is_shift && (steps != '0)) begin
                            // First step happens at the accept edge itself.
                            r_dout <= w_dout_step;
                            r_sout <= w_sout_step;
                            r_mode <= mode;
                            r_cnt  <= steps - CNT_W'(1);
                            if (steps == CNT_W'(1)) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                            end
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_dout <= w_dout_step;
                    r_sout <= w_sout_step;
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dout = r_dout;
    assign sout = r_sout;
    assign busy = (r_state == ST_RUN);
    assign done = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus randomized commands
// compared against an arithmetic model of load/clear/shift/rotate.
module tb_univ_shift_reg;

    localparam int W  = 4;
    localparam int CW = 3;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic [W-1:0]  din   = '0;
    logic          sin   = 1'b0;
    logic [2:0]    mode  = '0;
    logic [CW-1:0] steps = '0;
    logic          start = 1'b0;
    logic [W-1:0]  dout;
    logic          sout;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] m_dout = '0;
    logic         m_sout = 1'b0;

    univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .sin   (sin),
        .mode  (mode),
        .steps (steps),
        .start (start),
        .dout  (dout),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #40 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] md, input logic [W-1:0] d,
                         input logic [CW-1:0] n, input logic s);
        mode  = md;
        din   = d;
        steps = n;
        sin   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One shift/rotate step from the rules, as integer arithmetic; returns {sout, dout}.
    function automatic logic [W:0] step_ref(input logic [2:0] md, input logic [W-1:0] d,
                                            input logic s);
        int unsigned v, top, full, nv, ns;
        v    = d;
        top  = 1 << (W - 1);
        full = 1 << W;
        nv   = v;
        ns   = 0;
        case (md)
            M_SHL: begin nv = (v * 2 + s) % full;          ns = v / top; end
            M_SHR: begin nv = v / 2 + s * top;             ns = v % 2;   end
            M_ROL: begin nv = (v * 2) % full + v / top;    ns = v / top; end
            M_ROR: begin nv = v / 2 + (v % 2) * top;       ns = v % 2;   end
            default: ;
        endcase
        return {1'(ns), W'(nv)};
    endfunction

    task automatic test_reset();
        #45;
        checks += 4;
        if (dout !== 4'b0000) begin failures++; $display("FAIL reset_dout got=%b exp=0000", dout); end
        if (sout !== 1'b0)    begin failures++; $display("FAIL reset_sout got=%b exp=0", sout); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0)    begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        #5 rst = 1'b1;
        tick();
    endtask

    task automatic test_load();
        issue(M_LOAD, 4'b1010, '0, 1'b0);
        checks += 3;
        if (dout !== 4'b1010) begin failures++; $display("FAIL load_dout got=%b exp=1010", dout); end
        if (done !== 1'b1)    begin failures++; $display("FAIL load_done got=%b exp=1", done); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL load_busy got=%b exp=0", busy); end
        tick();
        checks += 2;
        if (done !== 1'b0) begin failures++; $display("FAIL load_done_clear got=%b exp=0", done); end
        if (busy !== 1'b0) begin failures++; $display("FAIL load_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_shift();
        issue(M_SHL, '0, 3'd1, 1'b1);
        checks += 4;
        if (dout !== 4'b0101) begin failures++; $display("FAIL shl1_dout got=%b exp=0101", dout); end
        if (sout !== 1'b1)    begin failures++; $display("FAIL shl1_sout got=%b exp=1", sout); end
        if (done !== 1'b1)    begin failures++; $display("FAIL shl1_done got=%b exp=1", done); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL shl1_busy got=%b exp=0", busy); end
        tick();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL shl1_done_clear got=%b exp=0", done); end
        issue(M_SHR, '0, 3'd2, 1'b0);
        checks += 4;
        if (dout !== 4'b0010) begin failures++; $display("FAIL shr2_e1_dout got=%b exp=0010", dout); end
        if (sout !== 1'b1)    begin failures++; $display("FAIL shr2_e1_sout got=%b exp=1", sout); end
        if (busy !== 1'b1)    begin failures++; $display("FAIL shr2_e1_busy got=%b exp=1", busy); end
        if (done !== 1'b0)    begin failures++; $display("FAIL shr2_e1_done got=%b exp=0", done); end
        tick();
        checks += 4;
        if (dout !== 4'b0001) begin failures++; $display("FAIL shr2_e2_dout got=%b exp=0001", dout); end
        if (sout !== 1'b0)    begin failures++; $display("FAIL shr2_e2_sout got=%b exp=0", sout); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL shr2_e2_busy got=%b exp=0", busy); end
        if (done !== 1'b1)    begin failures++; $display("FAIL shr2_e2_done got=%b exp=1", done); end
        tick();
    endtask

    task automatic test_rotate();
        logic [W-1:0] exp_d[3];
        logic         exp_b[3];
        exp_d[0] = 4'b0111; exp_d[1] = 4'b1011; exp_d[2] = 4'b1101;
        exp_b[0] = 1'b1;    exp_b[1] = 1'b1;    exp_b[2] = 1'b0;
        issue(M_LOAD, 4'b1110, '0, 1'b0);
        tick();
        issue(M_ROR, '0, 3'd3, 1'b0);
        for (int e = 0; e < 3; e++) begin
            checks += 3;
            if (dout !== exp_d[e]) begin failures++; $display("FAIL ror3_dout edge=%0d got=%b exp=%b", e + 1, dout, exp_d[e]); end
            if (busy !== exp_b[e]) begin failures++; $display("FAIL ror3_busy edge=%0d got=%b exp=%b", e + 1, busy, exp_b[e]); end
            if (done !== (e == 2)) begin failures++; $display("FAIL ror3_done edge=%0d got=%b exp=%b", e + 1, done, (e == 2)); end
            if (e < 2) tick();
        end
        checks++;
        if (sout !== 1'b1) begin failures++; $display("FAIL ror3_sout got=%b exp=1", sout); end
        tick();
    endtask

    task automatic test_ignore_start();
        int           n_done = 0;
        logic [W-1:0] d_at   = '0;
        logic         s_at   = 1'b0;
        issue(M_ROL, '0, 3'd5, 1'b0);
        mode  = M_LOAD;
        din   = 4'b0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) begin n_done++; d_at = dout; s_at = sout; end
            tick();
        end
        checks += 4;
        if (n_done != 1)      begin failures++; $display("FAIL rol5_done_count got=%0d exp=1", n_done); end
        if (d_at !== 4'b1011) begin failures++; $display("FAIL rol5_dout got=%b exp=1011", d_at); end
        if (s_at !== 1'b1)    begin failures++; $display("FAIL rol5_sout got=%b exp=1", s_at); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL rol5_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_zero_steps_clear();
        issue(M_SHL, '0, 3'd0, 1'b0);
        checks += 4;
        if (dout !== 4'b1011) begin failures++; $display("FAIL shl0_dout got=%b exp=1011", dout); end
        if (sout !== 1'b1)    begin failures++; $display("FAIL shl0_sout got=%b exp=1", sout); end
        if (done !== 1'b1)    begin failures++; $display("FAIL shl0_done got=%b exp=1", done); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL shl0_busy got=%b exp=0", busy); end
        tick();
        checks += 2;
        if (done !== 1'b0) begin failures++; $display("FAIL shl0_done_clear got=%b exp=0", done); end
        if (busy !== 1'b0) begin failures++; $display("FAIL shl0_busy_after got=%b exp=0", busy); end
        issue(M_CLR, 4'b1111, '0, 1'b0);
        checks += 3;
        if (dout !== 4'b0000) begin failures++; $display("FAIL clr_dout got=%b exp=0000", dout); end
        if (sout !== 1'b1)    begin failures++; $display("FAIL clr_sout got=%b exp=1", sout); end
        if (done !== 1'b1)    begin failures++; $display("FAIL clr_done got=%b exp=1", done); end
        issue(M_HOLD, 4'b0101, '0, 1'b0);
        checks += 2;
        if (dout !== 4'b0000) begin failures++; $display("FAIL hold_dout got=%b exp=0000", dout); end
        if (done !== 1'b1)    begin failures++; $display("FAIL hold_done got=%b exp=1", done); end
        tick();
    endtask

    task automatic test_async_reset();
        issue(M_LOAD, 4'b0110, '0, 1'b0);
        tick();
        issue(M_ROL, '0, 3'd6, 1'b0);
        tick();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL arst_pre_busy got=%b exp=1", busy); end
        #20 rst = 1'b0;
        #5;
        checks += 4;
        if (dout !== 4'b0000) begin failures++; $display("FAIL arst_dout got=%b exp=0000", dout); end
        if (sout !== 1'b0)    begin failures++; $display("FAIL arst_sout got=%b exp=0", sout); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
        if (done !== 1'b0)    begin failures++; $display("FAIL arst_done got=%b exp=0", done); end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks += 2;
            if (done !== 1'b0) begin failures++; $display("FAIL arst_no_done cyc=%0d got=%b exp=0", i, done); end
            if (dout !== 4'b0000) begin failures++; $display("FAIL arst_idle_dout cyc=%0d got=%b exp=0000", i, dout); end
        end
        issue(M_LOAD, 4'b1001, '0, 1'b0);
        checks += 3;
        if (dout !== 4'b1001) begin failures++; $display("FAIL arst_load_dout got=%b exp=1001", dout); end
        if (done !== 1'b1)    begin failures++; $display("FAIL arst_load_done got=%b exp=1", done); end
        if (busy !== 1'b0)    begin failures++; $display("FAIL arst_load_busy got=%b exp=0", busy); end
        tick();
    endtask

    // Random commands, issued back to back when done fires, with junk on the
    // command inputs while busy.
    task automatic test_random();
        logic [2:0]    md;
        logic [W-1:0]  d;
        logic [CW-1:0] n;
        logic [W:0]    r;
        bit            is_shift;
        int            total;
        m_dout = dout;
        m_sout = sout;
        for (int c = 0; c < 60; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b0;
                tick();
                checks += 3;
                if (done !== 1'b0)  begin failures++; $display("FAIL rnd_gap_done cmd=%0d got=%b exp=0", c, done); end
                if (busy !== 1'b0)  begin failures++; $display("FAIL rnd_gap_busy cmd=%0d got=%b exp=0", c, busy); end
                if (dout !== m_dout) begin failures++; $display("FAIL rnd_gap_dout cmd=%0d got=%b exp=%b", c, dout, m_dout); end
            end
            md       = 3'($urandom_range(0, 7));
            d        = W'($urandom);
            n        = CW'($urandom_range(0, 7));
            is_shift = (md >= M_SHL) && (md <= M_ROR);
            total    = (is_shift && n != 0) ? int'(n) : 1;
            mode  = md;
            din   = d;
            steps = n;
            sin   = 1'($urandom_range(0, 1));
            start = 1'b1;
            for (int e = 1; e <= total; e++) begin
                if (e == 1 && md == M_LOAD) m_dout = d;
                else if (e == 1 && md == M_CLR) m_dout = '0;
                else if (is_shift && n != 0) begin
                    r      = step_ref(md, m_dout, sin);
                    m_dout = r[W-1:0];
                    m_sout = r[W];
                end
                tick();
                checks += 4;
                if (dout !== m_dout) begin failures++; $display("FAIL rnd_dout cmd=%0d mode=%0d edge=%0d got=%b exp=%b", c, md, e, dout, m_dout); end
                if (sout !== m_sout) begin failures++; $display("FAIL rnd_sout cmd=%0d mode=%0d edge=%0d got=%b exp=%b", c, md, e, sout, m_sout); end
                if (busy !== (e < total)) begin failures++; $display("FAIL rnd_busy cmd=%0d mode=%0d edge=%0d got=%b exp=%b", c, md, e, busy, (e < total)); end
                if (done !== (e == total)) begin failures++; $display("FAIL rnd_done cmd=%0d mode=%0d edge=%0d got=%b exp=%b", c, md, e, done, (e == total)); end
                sin = 1'($urandom_range(0, 1));
                if (e < total) begin
                    mode  = 3'($urandom_range(0, 7));
                    din   = W'($urandom);
                    steps = CW'($urandom);
                    start = 1'($urandom_range(0, 1));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        tick();
        checks += 2;
        if (done !== 1'b0) begin failures++; $display("FAIL rnd_end_done got=%b exp=0", done); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rnd_end_busy got=%b exp=0", busy); end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_load();
        test_shift();
        test_rotate();
        test_ignore_start();
        test_zero_steps_clear();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
